// File: rtl/multu_unit_if.sv
// multu_unit_if: decoder/regfile <-> multiplier bus.
//   multu, mflo     : decoder strobes for the current instruction
//   rs_val, rt_val  : register-file read values (multiplicand, multiplier)
//   lo, hi          : HI/LO registers; lo is the mflo write-back data
//   busy, stall     : multiply in progress / freeze PC this cycle
//   done            : one-cycle pulse after HI/LO are updated
interface multu_unit_if #(
  parameter int WIDTH = 32
);
  logic             multu;
  logic             mflo;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output multu, mflo, rs_val, rt_val,
    input  lo, hi, busy, stall, done
  );

  modport slave (
    input  multu, mflo, rs_val, rt_val,
    output lo, hi, busy, stall, done
  );
endinterface

// File: rtl/multu_unit.sv
// multu_unit: iterative unsigned WIDTH x WIDTH multiplier with HI/LO registers.
// One shift-add step per cycle, WIDTH steps per product. HI/LO change only on
// the final step, so a partially formed product is never visible.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      multu_unit_if.slave (strobes, operands, hi/lo, busy/stall/done)
//
// state | meaning
// IDLE  | waiting for multu; hi/lo hold last product
// RUN   | shift-add iterations in progress, cnt = step index
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  multu_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 w_start;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_p_step;
  logic                 w_busy;

  // Upper half plus optional multiplicand; the carry lands in the top bit
  // after the right shift, so the full product is always exact.
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} +
                    (r_p[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_p_step = {w_sum, r_p[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.multu) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (r_cnt == CW'(WIDTH-1)) begin
          w_state_nxt = IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_start) begin
        r_mcand <= bus.rs_val;
        r_p     <= {{WIDTH{1'b0}}, bus.rt_val};
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_p   <= w_p_step;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_hi <= w_p_step[2*WIDTH-1:WIDTH];
          r_lo <= w_p_step[WIDTH-1:0];
        end
      end
    end
  end

  assign w_busy    = (r_state == RUN);
  assign bus.busy  = w_busy;
  // A stalled instruction is re-presented, so a multu seen while busy is
  // simply held off here and picked up once the unit returns to IDLE.
  assign bus.stall = w_busy & (bus.mflo | bus.multu);
  assign bus.lo    = r_lo;
  assign bus.hi    = r_hi;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: directed vectors for multu_unit with hand-computed products.
module tb_multu_unit;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_fails;

  multu_unit_if #(.WIDTH(32)) bus ();

  multu_unit #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Start a multiply, scramble operands during RUN, and check busy length,
  // HI/LO hold, done pulse and final product.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    logic [63:0] prev;
    int          n;
    int          early_done;
    prev = {bus.hi, bus.lo};
    bus.multu  = 1'b1;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    chk({tag, "_idle_stall"}, 64'(bus.stall), 64'd0);
    tick;
    bus.multu  = 1'b0;
    bus.rs_val = ~a;
    bus.rt_val = b ^ 32'h5A5A_A5A5;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    n = 1;
    early_done = 0;
    while (bus.busy && n < 40) begin
      if (bus.done) early_done++;
      if (n == 16) chk({tag, "_hold"}, {bus.hi, bus.lo}, prev);
      tick;
      if (bus.busy) n++;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_early_done"}, 64'(early_done), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_prod"}, {bus.hi, bus.lo}, exp);
    bus.mflo = 1'b1;
    #1;
    chk({tag, "_mflo_stall"}, 64'(bus.stall), 64'd0);
    chk({tag, "_mflo_lo"}, 64'(bus.lo), 64'(exp[31:0]));
    tick;
    bus.mflo = 1'b0;
    chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_idle_reached"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int dcount;
    n_checks   = 0;
    n_fails    = 0;
    i_rst_n    = 1'b0;
    bus.multu  = 1'b0;
    bus.mflo   = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) tick;
    chk("rst_lo",    64'(bus.lo), 64'd0);
    chk("rst_hi",    64'(bus.hi), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    i_rst_n = 1'b1;
    tick;

    run_mul("basic", 32'd7, 32'd6, 64'h0000_0000_0000_002A);
    run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_mul("carry", 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    run_mul("zero", 32'h0000_0000, 32'hDEAD_BEEF, 64'h0);

    // mflo presented 5 cycles into RUN stalls until the product lands.
    bus.multu  = 1'b1;
    bus.rs_val = 32'h0001_0000;
    bus.rt_val = 32'h0001_0001;
    tick;
    bus.multu  = 1'b0;
    repeat (4) tick;
    bus.rs_val = 32'hFFFF_FFFF;
    bus.rt_val = 32'h1234_5678;
    bus.mflo   = 1'b1;
    #1;
    chk("ilk_mflo_stall", 64'(bus.stall), 64'd1);
    chk("ilk_lo_old", 64'(bus.lo), 64'd0);
    wait_idle("ilk");
    chk("ilk_stall_drop", 64'(bus.stall), 64'd0);
    chk("ilk_prod", {bus.hi, bus.lo}, 64'h0000_0001_0001_0000);
    bus.mflo = 1'b0;
    tick;

    // multu held while busy is ignored, then accepted on the done cycle.
    bus.multu  = 1'b1;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd5;
    tick;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    #1;
    chk("b2b_multu_stall", 64'(bus.stall), 64'd1);
    wait_idle("b2b_first");
    chk("b2b_first_prod", {bus.hi, bus.lo}, 64'd25);
    chk("b2b_first_done", 64'(bus.done), 64'd1);
    chk("b2b_stall_drop", 64'(bus.stall), 64'd0);
    tick;
    bus.multu = 1'b0;
    chk("b2b_restart", 64'(bus.busy), 64'd1);
    wait_idle("b2b_second");
    chk("b2b_second_prod", {bus.hi, bus.lo}, 64'd81);

    // Abort: reset lands 10 cycles into RUN.
    tick;
    bus.multu  = 1'b1;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd5;
    tick;
    bus.multu = 1'b0;
    repeat (10) tick;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_prod", {bus.hi, bus.lo}, 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    repeat (3) tick;
    i_rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.done || bus.busy) dcount++;
    end
    chk("abort_quiet", 64'(dcount), 64'd0);
    bus.mflo = 1'b1;
    #1;
    chk("abort_mflo_stall", 64'(bus.stall), 64'd0);
    chk("abort_mflo_lo", 64'(bus.lo), 64'd0);
    bus.mflo = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
